booth_div: RTL
==============

// Module: booth_div
// PURPOSE
//  Sequential signed divider, the inverse of the combinational booth_mult (12x12->24) in the calculator datapath.
//  Divides a 2W-bit signed dividend (a booth_mult product) by a W-bit signed divisor.
//  Returns a W-bit quotient and a W-bit remainder (truncating division) over a start/done handshake.
//  Iterative restoring algorithm on magnitudes, one quotient bit per clock.
// PARAMETERS
//  W  12  divisor/quotient/remainder width; dividend is 2W bits
// PORTS
//  clk       in   1    rising-edge clock (single clock domain)
//  rst_n     in   1    asynchronous active-low reset
//  start     in   1    request; sampled only in IDLE or DONE
//  dividend  in   2W   signed dividend, sampled with start
//  divisor   in   W    signed divisor, sampled with start
//  busy      out  1    high in CALC/SIGN
//  done      out  1    one-cycle pulse: q/r/flags valid
//  q         out  W    signed quotient, held until next accepted start
//  r         out  W    signed remainder, sign follows dividend
//  dz        out  1    divide-by-zero flag, held with q/r
//  ovf       out  1    quotient overflow flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, q, r, dz, ovf all 0. Asynchronous assertion aborts any operation; results lost.
//  - States:
//    - IDLE: start -> latch |dividend|, |divisor|, operand signs; clear count; go to CALC.
//    - If divisor==0 at start: go straight to DONE with q=0, r=0, dz=1, ovf=0. done is high 1 cycle after start.
//    - CALC: 2W cycles. Per cycle: shift partial remainder (W+1 bits) left, bring in next dividend bit.
//      If remainder >= |divisor|, subtract and set quotient bit=1, else 0.
//      count 0..2W-1; at count==2W-1 go to SIGN.
//    - SIGN: negate q if sign(dividend)^sign(divisor); negate r if dividend<0; evaluate overflow; register outputs. Go to DONE.
//    - DONE: done=1 for exactly 1 cycle, busy=0.
//      start in DONE is accepted exactly as in IDLE (back-to-back); otherwise go to IDLE.
//  - Latency: start edge t -> done high in the cycle after edge t+2W+1 (t+25 for W=12).
//  - start while busy: ignored, no effect on operands or state.
//  - Internal quotient is 2W bits; |r| < |divisor| <= 2^(W-1), so r always fits in W bits exactly.
//  - -2^(2W-1) dividend: magnitude held in 2W bits unsigned; no special case.
//  - q, r, dz, ovf update only on the SIGN->DONE edge (or the divide-by-zero start edge). Otherwise they hold.
// CONFIGURATION
//  DIV_OVF_SAT_EN defined:
//    - If the signed quotient is outside [-2^(W-1), 2^(W-1)-1], ovf=1.
//    - q saturates to 2^(W-1)-1 (positive) or -2^(W-1) (negative). r is still the exact remainder.
//  DIV_OVF_SAT_EN undefined: ovf tied 0; q = low W bits of the true quotient (wraps).
// STRUCTURE
//  - Shared package booth_pkg: W default constant; state encoding IDLE/CALC/SIGN/DONE (2-bit localparams).
//    Also CNT_W = $clog2(2W).
//  - One sub-module div_step (combinational): in {rem W+1, next bit, |divisor|}, out {rem', qbit}.
//  - Top holds FSM, counter, operand/quotient shift registers and sign fix-up.
// TESTING
//  - dividend=-672, divisor=-12 -> q=56, r=0, dz=0, ovf=0; done exactly 25 cycles after start edge.
//  - dividend=1000, divisor=7 -> q=142, r=6.
//  - dividend=-1000, divisor=7 -> q=-142, r=-6.
//  - dividend=990, divisor=-30 -> q=-33, r=0.
//  - divisor=0, any dividend -> done 1 cycle after start; dz=1, q=0, r=0.
//  - Overflow: dividend=100000, divisor=3.
//    With DIV_OVF_SAT_EN: q=2047, ovf=1, r=1. Without: q=565, ovf=0, r=1.
//  - Handshake: start asserted during CALC is ignored; new start in the DONE cycle gives the next result 25 cycles later.
//    rst_n low mid-CALC forces all outputs to 0 and IDLE immediately.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the booth_mult / booth_div calculator datapath.
package booth_pkg;

    // Default operand width: booth_mult is 12x12->24, so the divider takes 24/12.
    localparam int W_DEF = 12;

    // Iteration counter width for a 2W-bit dividend.
    localparam int CNT_W = $clog2(2 * W_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor magnitude when it fits, and report the resulting quotient bit.
module div_step
    import booth_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W:0]   rem,
    input  logic         bit_in,
    input  logic [W-1:0] dvs,
    output logic [W:0]   rem_out,
    output logic         qbit
);

    logic [W:0] shifted;
    logic       rem_msb_unused;

    // The incoming remainder is always below |divisor| <= 2^(W-1), so its top
    // bit is zero and the shifted value still fits in W+1 bits.
    assign rem_msb_unused = rem[W];

    // Trial subtraction; keep the difference only when it does not go negative.
    always_comb begin
        shifted = {rem[W-1:0], bit_in};
        qbit    = (shifted >= {1'b0, dvs});
        rem_out = qbit ? (shifted - {1'b0, dvs}) : shifted;
    end

endmodule

// File: rtl/booth_div.sv
// Sequential signed divider (2W / W -> W quotient, W remainder), one quotient
// bit per clock on magnitudes with a final sign fix-up.
// Optional feature: define DIV_OVF_SAT_EN to flag and saturate quotients that
// do not fit in W signed bits; otherwise the quotient wraps and ovf stays 0.
module booth_div
    import booth_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   q,
    output logic [W-1:0]   r,
    output logic           dz,
    output logic           ovf
);

    localparam int             CW   = $clog2(2 * W);
    localparam logic [CW-1:0]  LAST = CW'(2 * W - 1);
`ifdef DIV_OVF_SAT_EN
    localparam logic [2*W-1:0] Q_POS_MAG = (2*W)'((64'd1 << (W - 1)) - 64'd1);
    localparam logic [2*W-1:0] Q_NEG_MAG = (2*W)'(64'd1 << (W - 1));
`endif

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] dvd_mag;    // dividend magnitude, shifts out MSB-first while quotient bits shift in
    logic [W-1:0]   dvs_mag;
    logic [W:0]     rem, rem_nxt;
    logic           qbit;
    logic           sgn_dvd, sgn_dvs, q_neg;
    logic           accept, div_zero;
    logic [2*W-1:0] dvd_abs;
    logic [W-1:0]   dvs_abs;
    logic [W-1:0]   q_low, q_fix, r_fix;
    logic           ovf_fix;

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign div_zero = (divisor == '0);
    assign q_neg    = sgn_dvd ^ sgn_dvs;

    div_step #(.W(W)) u_step (
        .rem     (rem),
        .bit_in  (dvd_mag[2*W-1]),
        .dvs     (dvs_mag),
        .rem_out (rem_nxt),
        .qbit    (qbit)
    );

    // Operand magnitudes; -2^(2W-1) maps to 2^(2W-1) as an unsigned value.
    always_comb begin
        dvd_abs = dividend[2*W-1] ? -dividend : dividend;
        dvs_abs = divisor[W-1]    ? -divisor  : divisor;
    end

    // Sign fix-up of the finished magnitudes, plus optional overflow saturation.
    always_comb begin
        q_low = q_neg   ? -dvd_mag[W-1:0] : dvd_mag[W-1:0];
        r_fix = sgn_dvd ? -rem[W-1:0]     : rem[W-1:0];
`ifdef DIV_OVF_SAT_EN
        ovf_fix = q_neg ? (dvd_mag > Q_NEG_MAG) : (dvd_mag > Q_POS_MAG);
        q_fix   = q_low;
        if (ovf_fix)
            q_fix = q_neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
        ovf_fix = 1'b0;
        q_fix   = q_low;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs; DONE accepts a new start like IDLE.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) state_nxt = div_zero ? DONE : CALC;
                else       state_nxt = IDLE;
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = SIGN;
            end
            SIGN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and result registers that hold
    // until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            dvd_mag <= '0;
            dvs_mag <= '0;
            rem     <= '0;
            sgn_dvd <= 1'b0;
            sgn_dvs <= 1'b0;
            q       <= '0;
            r       <= '0;
            dz      <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            if (div_zero) begin
                q   <= '0;
                r   <= '0;
                dz  <= 1'b1;
                ovf <= 1'b0;
            end else begin
                dvd_mag <= dvd_abs;
                dvs_mag <= dvs_abs;
                sgn_dvd <= dividend[2*W-1];
                sgn_dvs <= divisor[W-1];
                rem     <= '0;
                cnt     <= '0;
            end
        end else if (state == CALC) begin
            rem     <= rem_nxt;
            dvd_mag <= {dvd_mag[2*W-2:0], qbit};
            cnt     <= cnt + CW'(1);
        end else if (state == SIGN) begin
            q   <= q_fix;
            r   <= r_fix;
            dz  <= 1'b0;
            ovf <= ovf_fix;
        end
    end

endmodule
